// File: rtl/qupls_dispatch_queue.sv
// Decode-to-rename dispatch queue with serializing-instruction handling.
// Optional QUPLS_DISPQ_STATS_EN adds dispatch and stall counters.
package qupls_dispatch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        nop;
    logic        br;
    logic        cjb;
    logic        bsr;
    logic        load;
    logic        store;
    logic        lda;
    logic        fence;
    logic        mul;
    logic        mulu;
    logic        div;
    logic        divu;
    logic        fpu;
    logic        alu;
    logic        sync;
    logic        brk;
    logic        rti;
    logic        csr;
    logic        irq;
    logic        rex;
  } decode_bus_t;

  typedef enum logic [1:0] {
    RUN,
    SER_WAIT,
    SER_DRAIN
  } dq_state_e;
endpackage

module qupls_dispatch_queue
  import qupls_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_v,
  input  decode_bus_t                in_db,
  output logic                       in_rdy,
  output logic                       out_v,
  output decode_bus_t                out_db,
  output logic [5:0]                 out_unit,
  input  logic                       out_rdy,
  input  logic                       pipe_idle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       serial_busy,
  output logic [31:0]                stat_disp,
  output logic [31:0]                stat_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  decode_bus_t     mem_q  [DEPTH];
  decode_bus_t     mem_d  [DEPTH];
  logic [5:0]      unit_q [DEPTH];
  logic [5:0]      unit_d [DEPTH];
  logic            ser_q  [DEPTH];
  logic            ser_d  [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  dq_state_e       state_q, state_d;

  logic            push;
  logic            pop;
  logic            empty;
  logic            head_ser;
  logic [5:0]      unit_in;
  logic            ser_in;

  assign empty    = (count_q == '0);
  assign head_ser = ser_q[rptr_q];
  assign in_rdy   = (count_q < FULL) && !flush;
  assign push     = in_v && in_rdy && !in_db.nop;
  assign pop      = out_v && out_rdy;

  assign count       = count_q;
  assign serial_busy = (state_q != RUN);
  assign out_db      = empty ? '0 : mem_q[rptr_q];
  assign out_unit    = empty ? '0 : unit_q[rptr_q];

  // Unit class by first match; bit0 = BR ... bit5 = OTHER
  always_comb begin
    unit_in = 6'b100000;
    priority case (1'b1)
      in_db.br | in_db.cjb | in_db.bsr:
        unit_in = 6'b000001;
      in_db.load | in_db.store | in_db.lda | in_db.fence:
        unit_in = 6'b000010;
      in_db.mul | in_db.mulu | in_db.div | in_db.divu:
        unit_in = 6'b000100;
      in_db.fpu:
        unit_in = 6'b001000;
      in_db.alu:
        unit_in = 6'b010000;
      default:
        unit_in = 6'b100000;
    endcase
  end

  assign ser_in = in_db.sync | in_db.fence | in_db.brk |
                  in_db.rti  | in_db.csr   | in_db.irq |
                  in_db.rex;

  always_comb begin
    out_v = 1'b0;
    unique case (state_q)
      RUN:       out_v = !empty && !head_ser;
      SER_WAIT:  out_v = pipe_idle && !empty;
      SER_DRAIN: out_v = 1'b0;
      default:   out_v = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:       if (!empty && head_ser) state_d = SER_WAIT;
      SER_WAIT:  if (pop) state_d = SER_DRAIN;
      SER_DRAIN: if (pipe_idle) state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_comb begin
    mem_d   = mem_q;
    unit_d  = unit_q;
    ser_d   = ser_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q]  = in_db;
      unit_d[wptr_q] = unit_in;
      ser_d[wptr_q]  = ser_in;
      wptr_d         = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        unit_q[i] <= '0;
        ser_q[i]  <= 1'b0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      mem_q   <= mem_d;
      unit_q  <= unit_d;
      ser_q   <= ser_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

`ifdef QUPLS_DISPQ_STATS_EN
  logic [31:0] disp_q, disp_d;
  logic [31:0] stall_q, stall_d;

  // Counters ignore flush so they span branch misses
  always_comb begin
    disp_d  = disp_q;
    stall_d = stall_q;
    if (pop) disp_d = disp_q + 32'd1;
    if (!empty && !pop) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      stall_q <= '0;
    end else begin
      disp_q  <= disp_d;
      stall_q <= stall_d;
    end
  end

  assign stat_disp  = disp_q;
  assign stat_stall = stall_q;
`else
  assign stat_disp  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_qupls_dispatch_queue.sv
// Directed bench for qupls_dispatch_queue (DEPTH=4).
// Inputs change #1 after posedge; outputs checked before next edge.
module tb_qupls_dispatch_queue;
  import qupls_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_v;
  decode_bus_t in_db;
  logic        in_rdy;
  logic        out_v;
  decode_bus_t out_db;
  logic [5:0]  out_unit;
  logic        out_rdy;
  logic        pipe_idle;
  logic [2:0]  count;
  logic        serial_busy;
  logic [31:0] stat_disp;
  logic [31:0] stat_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qupls_dispatch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_v       (in_v),
    .in_db      (in_db),
    .in_rdy     (in_rdy),
    .out_v      (out_v),
    .out_db     (out_db),
    .out_unit   (out_unit),
    .out_rdy    (out_rdy),
    .pipe_idle  (pipe_idle),
    .count      (count),
    .serial_busy(serial_busy),
    .stat_disp  (stat_disp),
    .stat_stall (stat_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decode_bus_t mk(input logic [31:0] pc);
    decode_bus_t b;
    b     = '0;
    b.pc  = pc;
    b.ins = ~pc;
    return b;
  endfunction

  function automatic decode_bus_t mk_alu(input logic [31:0] pc);
    decode_bus_t b;
    b     = mk(pc);
    b.alu = 1'b1;
    return b;
  endfunction

  task automatic unit_chk(input string tag, input decode_bus_t b,
                          input logic [5:0] exp);
    in_db   = b;
    in_v    = 1'b1;
    out_rdy = 1'b0;
    tick();
    in_v = 1'b0;
    chk(tag, 64'(out_unit), 64'(exp));
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  initial begin
    decode_bus_t b;
    rst = 1'b1; flush = 1'b0; in_v = 1'b0; in_db = '0;
    out_rdy = 1'b0; pipe_idle = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_busy", 64'(serial_busy), 64'd0);
    chk("rst_sdisp", 64'(stat_disp), 64'd0);
    chk("rst_sstall", 64'(stat_stall), 64'd0);
    chk("rst_db_zero", 64'(out_db == '0), 64'd1);

    // fill
    in_v = 1'b1; in_db = mk_alu(32'd1);
    tick();
    chk("fill_lat_v", 64'(out_v), 64'd1);
    chk("fill_unit", 64'(out_unit), 64'b010000);
    chk("fill_head", 64'(out_db.pc), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      in_db = mk_alu(32'(i));
      tick();
    end
    chk("fill_count4", 64'(count), 64'd4);
    chk("fill_in_rdy0", 64'(in_rdy), 64'd0);
    in_db = mk_alu(32'd5);
    tick();
    chk("fill_held5", 64'(count), 64'd4);
    in_v = 1'b0; out_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 64'(out_db.pc), 64'(i));
      tick();
    end
    chk("drain_count0", 64'(count), 64'd0);
    chk("drain_db_zero", 64'(out_db == '0), 64'd1);

    // wrap: push/pop pairs
    in_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_db = mk_alu(32'(100 + i));
      tick();
      chk("wrap_count", 64'(count), 64'd1);
      chk("wrap_v", 64'(out_v), 64'd1);
      chk("wrap_pc", 64'(out_db.pc), 64'(100 + i));
    end
    in_v = 1'b0;
    tick();
    chk("wrap_end", 64'(count), 64'd0);
    out_rdy = 1'b0;

    // unit classification
    b = mk(32'd20); b.br = 1'b1; b.alu = 1'b1;
    unit_chk("unit_br_alu", b, 6'b000001);
    b = mk(32'd21); b.store = 1'b1;
    unit_chk("unit_mem", b, 6'b000010);
    b = mk(32'd22); b.mul = 1'b1; b.fpu = 1'b1;
    unit_chk("unit_muldiv", b, 6'b000100);
    b = mk(32'd23); b.fpu = 1'b1;
    unit_chk("unit_fpu", b, 6'b001000);
    b = mk(32'd24);
    unit_chk("unit_other", b, 6'b100000);

    // nop bundles
    in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = mk_alu(32'(30 + i)); b.nop = 1'b1;
      in_db = b;
      tick();
    end
    in_v = 1'b0;
    chk("nop_count", 64'(count), 64'd0);
    chk("nop_out_v", 64'(out_v), 64'd0);
    chk("nop_in_rdy", 64'(in_rdy), 64'd1);

    // serialize
    pipe_idle = 1'b0; out_rdy = 1'b0; in_v = 1'b1;
    in_db = mk_alu(32'd1); tick();
    b = mk(32'd2); b.csr = 1'b1;
    in_db = b; tick();
    in_db = mk_alu(32'd3); tick();
    in_v = 1'b0;
    chk("ser_count3", 64'(count), 64'd3);
    chk("ser_alu_v", 64'(out_v), 64'd1);
    out_rdy = 1'b1;
    tick();
    chk("ser_head_csr", 64'(out_db.pc), 64'd2);
    chk("ser_run_block", 64'(out_v), 64'd0);
    tick();
    chk("ser_wait_v", 64'(out_v), 64'd0);
    chk("ser_wait_busy", 64'(serial_busy), 64'd1);
    tick();
    chk("ser_wait_hold", 64'(count), 64'd2);
    pipe_idle = 1'b1;
    #1;
    chk("ser_wait_idle_v", 64'(out_v), 64'd1);
    tick();
    pipe_idle = 1'b0;
    #1;
    chk("ser_csr_popped", 64'(count), 64'd1);
    chk("ser_drain_v", 64'(out_v), 64'd0);
    chk("ser_drain_busy", 64'(serial_busy), 64'd1);
    tick();
    chk("ser_drain_hold", 64'(out_v), 64'd0);
    pipe_idle = 1'b1;
    tick();
    chk("ser_back_run", 64'(serial_busy), 64'd0);
    chk("ser_alu3_v", 64'(out_v), 64'd1);
    chk("ser_alu3_pc", 64'(out_db.pc), 64'd3);
    tick();
    chk("ser_end", 64'(count), 64'd0);

    // flush from SER_WAIT
    pipe_idle = 1'b0; out_rdy = 1'b0; in_v = 1'b1;
    b = mk(32'd10); b.csr = 1'b1;
    in_db = b; tick();
    in_db = mk_alu(32'd11); tick();
    in_db = mk_alu(32'd12); tick();
    chk("fl_count3", 64'(count), 64'd3);
    chk("fl_wait", 64'(serial_busy), 64'd1);
    flush = 1'b1; in_db = mk_alu(32'd99);
    #1;
    chk("fl_in_rdy0", 64'(in_rdy), 64'd0);
    tick();
    flush = 1'b0; in_v = 1'b0;
    chk("fl_count0", 64'(count), 64'd0);
    chk("fl_run", 64'(serial_busy), 64'd0);
    chk("fl_out_v", 64'(out_v), 64'd0);
    pipe_idle = 1'b1; in_v = 1'b1; in_db = mk_alu(32'd7);
    tick();
    in_v = 1'b0;
    chk("fl_after_pc", 64'(out_db.pc), 64'd7);
    chk("fl_after_cnt", 64'(count), 64'd1);

    // reset beats flush mid-operation
    in_v = 1'b1; in_db = mk_alu(32'd8);
    tick();
    in_v = 1'b0; rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_out_v", 64'(out_v), 64'd0);
    chk("mrst_db_zero", 64'(out_db == '0), 64'd1);

    // stats
    out_rdy = 1'b0; in_v = 1'b1;
    in_db = mk_alu(32'd1); tick();
    in_db = mk_alu(32'd2); tick();
    in_v = 1'b0;
    tick();
    tick();
    out_rdy = 1'b1;
    tick();
    tick();
    out_rdy = 1'b0;
    chk("st_count", 64'(count), 64'd0);
`ifdef QUPLS_DISPQ_STATS_EN
    chk("st_stall", 64'(stat_stall), 64'd3);
    chk("st_disp", 64'(stat_disp), 64'd2);
`else
    chk("st_stall", 64'(stat_stall), 64'd0);
    chk("st_disp", 64'(stat_disp), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
